// File: rtl/hier_node_pkg.sv
// rtl/hier_node_pkg.sv - shared types and limits for the hierarchy node controller
package hier_node_pkg;

    localparam int MAX_CHILDREN = 64;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

endpackage

// File: rtl/hier_node_ctrl_if.sv
// rtl/hier_node_ctrl_if.sv - parent command/response and child broadcast/collect bundle
interface hier_node_ctrl_if #(
    parameter int NUM_CHILDREN = 10,
    parameter int DATA_W       = 32
);
    logic                           req_valid;
    logic                           req_ready;
    logic [DATA_W-1:0]              req_data;
    logic [NUM_CHILDREN-1:0]        child_req_valid;
    logic [NUM_CHILDREN-1:0]        child_req_ready;
    logic [DATA_W-1:0]              child_req_data;
    logic [NUM_CHILDREN-1:0]        child_rsp_valid;
    logic [NUM_CHILDREN*DATA_W-1:0] child_rsp_data;
    logic                           rsp_valid;
    logic                           rsp_ready;
    logic [DATA_W-1:0]              rsp_data;
    logic [NUM_CHILDREN-1:0]        rsp_done_mask;
    logic                           rsp_timeout;

    modport slave (
        input  req_valid, req_data, child_req_ready, child_rsp_valid, child_rsp_data, rsp_ready,
        output req_ready, child_req_valid, child_req_data, rsp_valid, rsp_data, rsp_done_mask,
               rsp_timeout
    );

    modport master (
        output req_valid, req_data, child_req_ready, child_rsp_valid, child_rsp_data, rsp_ready,
        input  req_ready, child_req_valid, child_req_data, rsp_valid, rsp_data, rsp_done_mask,
               rsp_timeout
    );
endinterface

// File: rtl/hier_node_child_slot.sv
// rtl/hier_node_child_slot.sv - per-child accept/done tracking and response gating
module hier_node_child_slot #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              preset,
    input  logic              issue,
    input  logic              collect,
    input  logic              child_req_ready,
    input  logic              child_rsp_valid,
    input  logic [DATA_W-1:0] child_rsp_data,
    output logic              child_req_valid,
    output logic              accepted_nxt,
    output logic              done_nxt,
    output logic              done,
    output logic [DATA_W-1:0] rsp_masked
);
    logic accepted_q, accepted_d;
    logic done_q, done_d;
    logic handshake, hit;

    // A response is only honoured once the child holds (or is taking) the command.
    always_comb begin
        handshake       = issue && !accepted_q && child_req_ready;
        hit             = collect && child_rsp_valid && !done_q && (accepted_q || handshake);
        accepted_d      = start ? preset : (accepted_q || handshake);
        done_d          = start ? preset : (done_q || hit);
        child_req_valid = issue && !accepted_q;
        rsp_masked      = hit ? child_rsp_data : '0;
        accepted_nxt    = accepted_d;
        done_nxt        = done_d;
    end

    assign done = done_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            accepted_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            accepted_q <= accepted_d;
            done_q     <= done_d;
        end
    end
endmodule

// File: rtl/hier_node_ctrl.sv
// rtl/hier_node_ctrl.sv - broadcast one command to N children, XOR-merge their responses (option: HIER_NODE_CHILD_MASK_EN)
module hier_node_ctrl
    import hier_node_pkg::*;
#(
    parameter int NUM_CHILDREN = 10,
    parameter int DATA_W       = 32,
    parameter int TMO_W        = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [TMO_W-1:0]        timeout_limit,
`ifdef HIER_NODE_CHILD_MASK_EN
    input  logic [NUM_CHILDREN-1:0] child_en,
`endif
    hier_node_ctrl_if.slave         bus
);
    state_t                             state_q, state_d;
    logic                               req_ready_q, req_ready_d;
    logic                               rsp_valid_q, rsp_valid_d;
    logic                               timeout_q, timeout_d;
    logic [DATA_W-1:0]                  cmd_q, cmd_d;
    logic [DATA_W-1:0]                  acc_q, acc_d;
    logic [TMO_W-1:0]                   timer_q, timer_d;
    logic [DATA_W-1:0]                  red;
    logic [NUM_CHILDREN-1:0]            en, crv, accepted_nxt, done_nxt, done_mask;
    logic [NUM_CHILDREN-1:0][DATA_W-1:0] masked;
    logic                               start, issue, collect, tmo_hit;

`ifdef HIER_NODE_CHILD_MASK_EN
    assign en = child_en;
`else
    assign en = '1;
`endif

    always_comb begin
        start   = (state_q == ST_IDLE) && req_ready_q && bus.req_valid;
        issue   = (state_q == ST_ISSUE);
        collect = issue || (state_q == ST_WAIT);
        tmo_hit = (timeout_limit != '0) && (timer_q == timeout_limit - 1'b1);
    end

    for (genvar i = 0; i < NUM_CHILDREN; i++) begin : g_slot
        hier_node_child_slot #(.DATA_W(DATA_W)) u_slot (
            .clk            (clk),
            .rst            (rst),
            .start          (start),
            .preset         (!en[i]),
            .issue          (issue),
            .collect        (collect),
            .child_req_ready(bus.child_req_ready[i]),
            .child_rsp_valid(bus.child_rsp_valid[i]),
            .child_rsp_data (bus.child_rsp_data[i*DATA_W +: DATA_W]),
            .child_req_valid(crv[i]),
            .accepted_nxt   (accepted_nxt[i]),
            .done_nxt       (done_nxt[i]),
            .done           (done_mask[i]),
            .rsp_masked     (masked[i])
        );
    end

    always_comb begin
        red = '0;
        for (int i = 0; i < NUM_CHILDREN; i++) begin
            red = red ^ masked[i];
        end
    end

    // Completion is tested before timeout so a last response on the deadline still wins.
    always_comb begin
        state_d   = state_q;
        cmd_d     = cmd_q;
        acc_d     = acc_q;
        timer_d   = timer_q;
        timeout_d = timeout_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    cmd_d     = bus.req_data;
                    acc_d     = '0;
                    timer_d   = '0;
                    timeout_d = 1'b0;
                    state_d   = (en == '0) ? ST_RESP : ST_ISSUE;
                end
            end
            ST_ISSUE, ST_WAIT: begin
                acc_d   = acc_q ^ red;
                timer_d = (&timer_q) ? timer_q : timer_q + 1'b1;
                if (&done_nxt) begin
                    state_d = ST_RESP;
                end else if (tmo_hit) begin
                    state_d   = ST_RESP;
                    timeout_d = 1'b1;
                end else if (issue && (&accepted_nxt)) begin
                    state_d = ST_WAIT;
                end
            end
            ST_RESP: begin
                if (bus.rsp_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        req_ready_d = (state_d == ST_IDLE);
        rsp_valid_d = (state_d == ST_RESP);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            req_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            timeout_q   <= 1'b0;
            cmd_q       <= '0;
            acc_q       <= '0;
            timer_q     <= '0;
        end else begin
            state_q     <= state_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            timeout_q   <= timeout_d;
            cmd_q       <= cmd_d;
            acc_q       <= acc_d;
            timer_q     <= timer_d;
        end
    end

    assign bus.req_ready       = req_ready_q;
    assign bus.child_req_valid = crv;
    assign bus.child_req_data  = cmd_q;
    assign bus.rsp_valid       = rsp_valid_q;
    assign bus.rsp_data        = acc_q;
    assign bus.rsp_done_mask   = done_mask;
    assign bus.rsp_timeout     = timeout_q;
endmodule

// File: tb/tb_hier_node_ctrl.sv
// tb/tb_hier_node_ctrl.sv - directed and randomized transactions against a per-transaction outcome model
module tb_hier_node_ctrl;
    localparam int NC    = 10;
    localparam int DW    = 32;
    localparam int TW    = 16;
    localparam int NEVER = 1 << 30;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [TW-1:0] timeout_limit = '0;
    logic [NC-1:0] child_en = '1;
    int            checks = 0;
    int            errors = 0;

    hier_node_ctrl_if #(.NUM_CHILDREN(NC), .DATA_W(DW)) bus ();

    hier_node_ctrl #(.NUM_CHILDREN(NC), .DATA_W(DW), .TMO_W(TW)) dut (
        .clk          (clk),
        .rst          (rst),
        .timeout_limit(timeout_limit),
`ifdef HIER_NODE_CHILD_MASK_EN
        .child_en     (child_en),
`endif
        .bus          (bus.slave)
    );

    always #5 clk = ~clk;

    int            rdy_dly[NC];
    int            p1[NC];
    int            p2[NC];
    logic [DW-1:0] d1[NC];
    logic [DW-1:0] d2[NC];
    int            hold;
    int            exp_end;
    logic [DW-1:0] exp_data;
    logic [NC-1:0] exp_mask;
    logic          exp_tmo;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_children;
        bus.child_req_ready = '0;
        bus.child_rsp_valid = '0;
        bus.child_rsp_data  = '0;
    endtask

    task automatic set_defaults;
        for (int i = 0; i < NC; i++) begin
            rdy_dly[i] = 0;
            p1[i]      = 0;
            p2[i]      = -1;
            d1[i]      = DW'(i + 1);
            d2[i]      = 32'hDEAD_0000 | DW'(i);
        end
        timeout_limit = '0;
        hold          = 0;
        child_en      = '1;
    endtask

    // Outcome per transaction: which children finish, when the node stops waiting, and the XOR.
    task automatic model;
        int done_at[NC];
        int t_done;
        int t_to;
        t_done = -1;
        for (int i = 0; i < NC; i++) begin
            if (!child_en[i])           done_at[i] = -1;
            else if (p1[i] >= rdy_dly[i]) done_at[i] = p1[i];
            else if (p2[i] >= rdy_dly[i]) done_at[i] = p2[i];
            else                          done_at[i] = NEVER;
            if (child_en[i] && done_at[i] > t_done) t_done = done_at[i];
        end
        t_to     = (timeout_limit == 0) ? NEVER : int'(timeout_limit) - 1;
        exp_tmo  = (t_done > t_to);
        exp_end  = exp_tmo ? t_to : t_done;
        exp_data = '0;
        exp_mask = ~child_en;
        for (int i = 0; i < NC; i++) begin
            if (child_en[i] && done_at[i] <= exp_end) begin
                exp_mask[i] = 1'b1;
                exp_data    = exp_data ^ ((done_at[i] == p1[i]) ? d1[i] : d2[i]);
            end
        end
    endtask

    task automatic run_txn(input string name);
        logic [DW-1:0] cmd;
        logic [NC-1:0] ev;
        int            c;
        int            w;
        cmd = $urandom;
        w   = 0;
        while (!bus.req_ready && w < 20) begin
            cyc();
            w++;
        end
        chk({name, ":req_ready_idle"}, bus.req_ready, 1);
        bus.req_valid = 1'b1;
        bus.req_data  = cmd;
        model();
        cyc();
        bus.req_valid = 1'b0;
        chk({name, ":req_ready_busy"}, bus.req_ready, 0);
        c = 0;
        while (!bus.rsp_valid && c < 200) begin
            for (int i = 0; i < NC; i++) begin
                bus.child_req_ready[i] = (c >= rdy_dly[i]);
                bus.child_rsp_valid[i] = (c == p1[i]) || (c == p2[i]);
                bus.child_rsp_data[i*DW +: DW] = (c == p2[i]) ? d2[i] : d1[i];
                ev[i] = child_en[i] && (c <= rdy_dly[i]);
            end
            chk({name, ":child_req_valid"}, bus.child_req_valid, ev);
            if (c == 0) chk({name, ":child_req_data"}, bus.child_req_data, cmd);
            cyc();
            c++;
        end
        clear_children();
        chk({name, ":latency"}, c, exp_end + 1);
        chk({name, ":rsp_valid"}, bus.rsp_valid, 1);
        for (int k = 0; k < hold; k++) begin
            bus.req_valid = 1'b1;
            bus.req_data  = ~cmd;
            chk({name, ":hold_req_ready"}, bus.req_ready, 0);
            chk({name, ":hold_rsp_valid"}, bus.rsp_valid, 1);
            chk({name, ":hold_rsp_data"}, bus.rsp_data, exp_data);
            cyc();
        end
        bus.req_valid = 1'b0;
        chk({name, ":rsp_data"}, bus.rsp_data, exp_data);
        chk({name, ":rsp_done_mask"}, bus.rsp_done_mask, exp_mask);
        chk({name, ":rsp_timeout"}, bus.rsp_timeout, exp_tmo);
        bus.rsp_ready = 1'b1;
        cyc();
        bus.rsp_ready = 1'b0;
        chk({name, ":rsp_valid_drop"}, bus.rsp_valid, 0);
        chk({name, ":req_ready_after"}, bus.req_ready, 1);
    endtask

    task automatic chk_reset_values(input string name);
        chk({name, ":req_ready"}, bus.req_ready, 0);
        chk({name, ":child_req_valid"}, bus.child_req_valid, 0);
        chk({name, ":child_req_data"}, bus.child_req_data, 0);
        chk({name, ":rsp_valid"}, bus.rsp_valid, 0);
        chk({name, ":rsp_data"}, bus.rsp_data, 0);
        chk({name, ":rsp_done_mask"}, bus.rsp_done_mask, 0);
        chk({name, ":rsp_timeout"}, bus.rsp_timeout, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        bus.req_valid = 1'b0;
        bus.req_data  = '0;
        bus.rsp_ready = 1'b0;
        clear_children();
        set_defaults();
        rst = 1'b1;
        cyc();
        cyc();
        chk_reset_values("reset");
        rst = 1'b0;
        cyc();
        chk("reset:req_ready_release", bus.req_ready, 1);

        set_defaults();
        run_txn("min_latency");

        set_defaults();
        for (int i = 0; i < NC; i++) p1[i] = 1;
        run_txn("xor_1_10");

        set_defaults();
        rdy_dly[3] = 5;
        for (int i = 0; i < NC; i++) p1[i] = rdy_dly[i] + 1;
        run_txn("slow_child3");

        set_defaults();
        timeout_limit = 20;
        p1[7]         = -1;
        run_txn("timeout_child7");

        set_defaults();
        p1[2] = 2;
        p2[2] = 4;
        run_txn("double_pulse");

        set_defaults();
        hold = 4;
        run_txn("rsp_backpressure");

        set_defaults();
        bus.req_valid       = 1'b1;
        bus.req_data        = 32'h1234_5678;
        cyc();
        bus.req_valid       = 1'b0;
        bus.child_req_ready = '1;
        cyc();
        cyc();
        chk("wait:child_req_valid", bus.child_req_valid, 0);
        rst = 1'b1;
        clear_children();
        cyc();
        chk_reset_values("mid_reset");
        rst = 1'b0;
        cyc();
        chk("mid_reset:req_ready", bus.req_ready, 1);
        run_txn("after_reset");

`ifdef HIER_NODE_CHILD_MASK_EN
        set_defaults();
        child_en = 10'h005;
        run_txn("child_en_005");
        set_defaults();
        child_en = '0;
        run_txn("child_en_none");
`endif

        for (int t = 0; t < 25; t++) begin
            set_defaults();
            timeout_limit = ($urandom_range(0, 1) == 1) ? TW'($urandom_range(1, 25)) : '0;
            hold          = $urandom_range(0, 3);
`ifdef HIER_NODE_CHILD_MASK_EN
            child_en = NC'($urandom);
`endif
            for (int i = 0; i < NC; i++) begin
                rdy_dly[i] = $urandom_range(0, 6);
                p1[i]      = ($urandom_range(0, 9) == 0) ? -1 : int'($urandom_range(0, 8));
                p2[i]      = ($urandom_range(0, 2) == 0) ? p1[i] + int'($urandom_range(1, 4)) : -1;
                if (p1[i] < 0) p2[i] = -1;
                d1[i]      = $urandom;
                d2[i]      = $urandom;
                if (timeout_limit == 0 && p1[i] < rdy_dly[i] && p2[i] < rdy_dly[i]) begin
                    p2[i] = rdy_dly[i] + 1;
                end
            end
            run_txn("random");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/hier_node_ctrl.md
Name: hier_node_ctrl

Overview:
Parametrised hierarchy node controller that replaces fixed fan-out structural nodes. It accepts one command from its parent and broadcasts it to NUM_CHILDREN child channels. It then collects one response per child, XOR-reduces the response data and returns a single aggregated response upward. A programmable timeout bounds the wait for unresponsive children.

Parameters:
NUM_CHILDREN, 10, number of child channels (1..64)
DATA_W, 32, command/response payload width
TMO_W, 16, width of timeout counter and limit

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
timeout_limit  input  TMO_W  cycles allowed from entering ISSUE; 0 = no timeout
req_valid  input  1  parent command valid
req_ready  output  1  parent command accepted
req_data  input  DATA_W  parent command payload
child_req_valid  output  NUM_CHILDREN  per-child command valid
child_req_ready  input  NUM_CHILDREN  per-child command accept
child_req_data  output  DATA_W  broadcast payload, shared by all children
child_rsp_valid  input  NUM_CHILDREN  per-child response pulse, one cycle
child_rsp_data  input  NUM_CHILDREN*DATA_W  per-child response; child i uses bits [i*DATA_W +: DATA_W]
rsp_valid  output  1  aggregated response valid
rsp_ready  input  1  parent accepts response
rsp_data  output  DATA_W  XOR of all collected child responses
rsp_done_mask  output  NUM_CHILDREN  children that responded
rsp_timeout  output  1  response ended by timeout

Behaviour:
- Single clock clk. rst is synchronous and active-high.
- Reset values: req_ready=0, child_req_valid=0, child_req_data=0, rsp_valid=0, rsp_data=0, rsp_done_mask=0, rsp_timeout=0. State=IDLE. Counters and masks are cleared.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid, capture req_data into child_req_data, clear accepted_mask, done_mask, the XOR accumulator and the timer, then go to ISSUE.
- ISSUE:
  - child_req_valid = ~accepted_mask.
  - A child handshake (valid&ready) sets its accepted_mask bit in the same cycle.
  - When all bits are set, go to WAIT.
- Response collection (ISSUE and WAIT):
  - child_rsp_valid[i] is honoured in both states, but only if accepted_mask[i] is set, or child i is accepting in that same cycle.
  - On a valid response, done_mask[i] sets and acc ^= child i's response data.
  - A second pulse from a child whose done bit is already set is ignored.
  - When done_mask becomes all-ones, go to RESP with rsp_timeout=0.
  - If that happens during ISSUE, go directly to RESP.
- Timeout:
  - The timer increments every cycle in ISSUE and WAIT, saturating at its maximum value.
  - If timeout_limit!=0 and the timer equals timeout_limit-1 without completion, go to RESP with rsp_timeout=1.
  - On timeout, child_req_valid drops to 0.
- Completion and timeout in the same cycle: completion wins, rsp_timeout=0.
- RESP:
  - rsp_valid=1; rsp_data, rsp_done_mask and rsp_timeout are held stable.
  - On rsp_ready, go to IDLE.
  - rsp_valid drops the cycle after the handshake.
  - req_ready is 0 until IDLE, so at most one command is outstanding.
- Minimum latency: command accept to rsp_valid is 2 cycles, when all children accept and respond in the first ISSUE cycle.
- rst mid-operation: abort immediately to IDLE with reset values. No response is issued for the aborted command.
- Responses arriving in IDLE or RESP are dropped.

Optional Feature:
Macro HIER_NODE_CHILD_MASK_EN.
- When defined:
  - Adds input child_en (NUM_CHILDREN bits), sampled on command accept.
  - Disabled children have their accepted_mask and done_mask bits preset to 1.
  - Disabled children never see child_req_valid and contribute nothing to rsp_data.
  - If child_en=0, go from IDLE straight to RESP with rsp_data=0 and rsp_done_mask=all-ones.
- When undefined: the port is absent and all children are always enabled.

Decomposition:
- Package hier_node_pkg holds:
  - state enum (IDLE, ISSUE, WAIT, RESP), 2-bit encoded;
  - localparam for the maximum child count.
- Sub-module hier_node_child_slot, one instance per child (generate loop). It holds the accepted and done flags, the valid gating and the masked response data. The parent performs the XOR reduction and runs the FSM and timer.

Test Plan:
- NUM_CHILDREN=10, all children ready and responding next cycle with data=i+1 → rsp_valid, rsp_data=0x0000000B (XOR of 1..10), rsp_done_mask=0x3FF, rsp_timeout=0.
- Child 3 holds ready low for 5 cycles, others accept immediately → only child_req_valid[3] stays high until it accepts; the response waits for child 3.
- timeout_limit=20, child 7 never responds → rsp_valid at cycle 20 after accept, rsp_timeout=1, rsp_done_mask=0x37F.
- Child 2 pulses response twice with different data → only the first pulse is XORed; rsp_data excludes the second.
- rsp_ready held low 4 cycles in RESP; new req_valid asserted → rsp outputs stable, req_ready=0 until the cycle after the handshake.
- rst asserted in WAIT → next cycle all outputs are at reset values; a new command then completes normally. With HIER_NODE_CHILD_MASK_EN and child_en=0x005 → only children 0 and 2 are driven, and rsp_done_mask=0x3FF.
